// File: rtl/conv3x3_mac_if.sv
// Signal bundle between the 3x3 line buffer / weight loader (master) and the
// conv3x3_mac stage (slave): nine window taps, the weight load port and the result.
interface conv3x3_mac_if #(
    parameter int BIT = 16
);
    logic signed [BIT-1:0] i_data0;
    logic signed [BIT-1:0] i_data1;
    logic signed [BIT-1:0] i_data2;
    logic signed [BIT-1:0] i_data3;
    logic signed [BIT-1:0] i_data4;
    logic signed [BIT-1:0] i_data5;
    logic signed [BIT-1:0] i_data6;
    logic signed [BIT-1:0] i_data7;
    logic signed [BIT-1:0] i_data8;
    logic                  valid_in;
    logic signed [BIT-1:0] w_data;
    logic                  w_valid;
    logic                  w_clear;
    logic                  w_ready;
    logic signed [BIT-1:0] o_data;
    logic                  valid_out;

    modport master (
        output i_data0, i_data1, i_data2, i_data3, i_data4,
        output i_data5, i_data6, i_data7, i_data8,
        output valid_in, w_data, w_valid, w_clear,
        input  w_ready, o_data, valid_out
    );

    modport slave (
        input  i_data0, i_data1, i_data2, i_data3, i_data4,
        input  i_data5, i_data6, i_data7, i_data8,
        input  valid_in, w_data, w_valid, w_clear,
        output w_ready, o_data, valid_out
    );
endinterface

// File: rtl/conv3x3_mac.sv
// Four-stage 3x3 convolution MAC: multiply taps by loaded weights, add rows,
// add bias, then round half up, saturate and optionally clamp negatives (ReLU).
module conv3x3_mac #(
    parameter int BIT  = 16,
    parameter int FRAC = 8,
    parameter bit RELU = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    conv3x3_mac_if.slave bus
);
    localparam int PW = 2 * BIT;
    localparam int RW = 2 * BIT + 2;
    localparam int AW = 2 * BIT + 4;
    localparam int TW = AW + 1;
    localparam logic [3:0] BIAS_IDX = 4'd9;
    localparam logic signed [TW-1:0]  HALF_C = TW'(1'b1) << (FRAC - 1);
    localparam logic signed [BIT-1:0] MAX_C  = {1'b0, {(BIT-1){1'b1}}};
    localparam logic signed [BIT-1:0] MIN_C  = {1'b1, {(BIT-1){1'b0}}};

    logic signed [BIT-1:0] tap_s [9];
    logic                  accept_s;

    logic [3:0]            w_cnt_q, w_cnt_d;
    logic                  w_ready_q, w_ready_d;
    logic signed [BIT-1:0] w_q [9];
    logic signed [BIT-1:0] w_d [9];
    logic signed [BIT-1:0] b_q, b_d;

    logic                  v1_q, v2_q, v3_q, vo_q;
    logic signed [PW-1:0]  p_q [9];
    logic signed [RW-1:0]  r_q [3];
    logic signed [AW-1:0]  acc_q;
    logic signed [TW-1:0]  rnd_s;
    logic signed [BIT-1:0] sat_s, res_s;
    logic signed [BIT-1:0] od_q;

    assign tap_s[0] = bus.i_data0;
    assign tap_s[1] = bus.i_data1;
    assign tap_s[2] = bus.i_data2;
    assign tap_s[3] = bus.i_data3;
    assign tap_s[4] = bus.i_data4;
    assign tap_s[5] = bus.i_data5;
    assign tap_s[6] = bus.i_data6;
    assign tap_s[7] = bus.i_data7;
    assign tap_s[8] = bus.i_data8;

    // A window only enters the pipe once the full weight set is in place
    assign accept_s = bus.valid_in & w_ready_q;

    // Weight/bias load sequencer; clear beats a coincident load word
    always_comb begin
        w_cnt_d   = w_cnt_q;
        w_ready_d = w_ready_q;
        w_d       = w_q;
        b_d       = b_q;
        if (bus.w_clear) begin
            w_cnt_d   = 4'd0;
            w_ready_d = 1'b0;
        end else if (bus.w_valid) begin
            if (w_cnt_q >= BIAS_IDX) begin
                b_d       = bus.w_data;
                w_cnt_d   = 4'd0;
                w_ready_d = 1'b1;
            end else begin
                for (int k = 0; k < 9; k++) begin
                    if (w_cnt_q == 4'(k)) begin
                        w_d[k] = bus.w_data;
                    end else begin
                        w_d[k] = w_q[k];
                    end
                end
                w_cnt_d = w_cnt_q + 4'd1;
            end
        end else begin
            w_cnt_d = w_cnt_q;
        end
    end

    // Weight/bias state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cnt_q   <= 4'd0;
            w_ready_q <= 1'b0;
            b_q       <= '0;
            for (int k = 0; k < 9; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            w_cnt_q   <= w_cnt_d;
            w_ready_q <= w_ready_d;
            b_q       <= b_d;
            w_q       <= w_d;
        end
    end

    // S1: nine full-precision tap x weight products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                p_q[k] <= '0;
            end
        end else begin
            v1_q <= accept_s;
            if (accept_s) begin
                for (int k = 0; k < 9; k++) begin
                    p_q[k] <= PW'(tap_s[k]) * PW'(w_q[k]);
                end
            end else begin
                p_q <= p_q;
            end
        end
    end

    // S2: per-row sums
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                r_q[r] <= '0;
            end
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                for (int r = 0; r < 3; r++) begin
                    r_q[r] <= RW'(p_q[3*r]) + RW'(p_q[3*r+1]) + RW'(p_q[3*r+2]);
                end
            end else begin
                r_q <= r_q;
            end
        end
    end

    // S3: total plus bias aligned to the product's fractional point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                acc_q <= AW'(r_q[0]) + AW'(r_q[1]) + AW'(r_q[2]) + (AW'(b_q) <<< FRAC);
            end else begin
                acc_q <= acc_q;
            end
        end
    end

    // One spare bit so the rounding add can never wrap
    assign rnd_s = (TW'(acc_q) + HALF_C) >>> FRAC;

    // S4 combinational part: saturate to the output range, then optional ReLU
    always_comb begin
        sat_s = rnd_s[BIT-1:0];
        if (rnd_s > TW'(MAX_C)) begin
            sat_s = MAX_C;
        end else if (rnd_s < TW'(MIN_C)) begin
            sat_s = MIN_C;
        end else begin
            sat_s = rnd_s[BIT-1:0];
        end
        res_s = sat_s;
        if (RELU && sat_s[BIT-1]) begin
            res_s = '0;
        end else begin
            res_s = sat_s;
        end
    end

    // S4: output register; o_data holds between results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vo_q <= 1'b0;
            od_q <= '0;
        end else begin
            vo_q <= v3_q;
            if (v3_q) begin
                od_q <= res_s;
            end else begin
                od_q <= od_q;
            end
        end
    end

    assign bus.w_ready   = w_ready_q;
    assign bus.valid_out = vo_q;
    assign bus.o_data    = od_q;
endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed-plus-random bench for conv3x3_mac: two instances (RELU=0 / RELU=1)
// share one stimulus and are compared against an arithmetic reference model.
module tb_conv3x3_mac;
    localparam int BIT  = 16;
    localparam int FRAC = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic signed [BIT-1:0] taps [9];
    logic                  vin, wv, wc;
    logic signed [BIT-1:0] wd;

    int     n_assert = 0;
    int     n_fail   = 0;
    longint mw [9];
    longint mb;
    longint e0q [20];
    longint e1q [20];

    conv3x3_mac_if #(.BIT(BIT)) bus0 ();
    conv3x3_mac_if #(.BIT(BIT)) bus1 ();

    assign bus0.i_data0 = taps[0];
    assign bus0.i_data1 = taps[1];
    assign bus0.i_data2 = taps[2];
    assign bus0.i_data3 = taps[3];
    assign bus0.i_data4 = taps[4];
    assign bus0.i_data5 = taps[5];
    assign bus0.i_data6 = taps[6];
    assign bus0.i_data7 = taps[7];
    assign bus0.i_data8 = taps[8];
    assign bus0.valid_in = vin;
    assign bus0.w_data   = wd;
    assign bus0.w_valid  = wv;
    assign bus0.w_clear  = wc;
    assign bus1.i_data0 = taps[0];
    assign bus1.i_data1 = taps[1];
    assign bus1.i_data2 = taps[2];
    assign bus1.i_data3 = taps[3];
    assign bus1.i_data4 = taps[4];
    assign bus1.i_data5 = taps[5];
    assign bus1.i_data6 = taps[6];
    assign bus1.i_data7 = taps[7];
    assign bus1.i_data8 = taps[8];
    assign bus1.valid_in = vin;
    assign bus1.w_data   = wd;
    assign bus1.w_valid  = wv;
    assign bus1.w_clear  = wc;

    conv3x3_mac #(.BIT(BIT), .FRAC(FRAC), .RELU(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    conv3x3_mac #(.BIT(BIT), .FRAC(FRAC), .RELU(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint rnd(input longint lo, input longint hi);
        return longint'($urandom_range(32'd0, 32'(hi - lo))) + lo;
    endfunction

    // Reference: exact sum, floor((sum + half) / 2^FRAC), clamp, optional ReLU
    function automatic longint ref_pixel(input bit relu);
        longint acc, num, d, q;
        d   = longint'(1) << FRAC;
        acc = mb * d;
        for (int k = 0; k < 9; k++) begin
            acc += longint'(taps[k]) * mw[k];
        end
        num = acc + d / 2;
        q   = num / d;
        if ((num % d) != 0 && num < 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        if (relu && q < 0) q = 0;
        return q;
    endfunction

    task automatic set_taps(input longint v);
        for (int k = 0; k < 9; k++) taps[k] = BIT'(v);
    endtask

    task automatic rand_taps();
        for (int k = 0; k < 9; k++) taps[k] = BIT'(rnd(-32768, 32767));
    endtask

    // Clear (optionally with a coincident word that must be ignored), then 10 words
    task automatic load_words(input bit drop_win, input bit coincide);
        wc = 1'b1;
        wv = coincide;
        wd = 16'sh7abc;
        tick();
        wc = 1'b0;
        wv = 1'b0;
        chk("clear_ready", bus0.w_ready, 0);
        for (int i = 0; i < 10; i++) begin
            wd  = (i < 9) ? BIT'(mw[i]) : BIT'(mb);
            wv  = 1'b1;
            vin = (i == 9) ? drop_win : 1'b0;
            tick();
            if (i == 8) chk("ready_early", bus0.w_ready, 0);
            else if (i == 9) chk("ready_set", bus0.w_ready, 1);
        end
        wv  = 1'b0;
        vin = 1'b0;
    endtask

    task automatic run_window(input string tag);
        longint e0, e1;
        e0  = ref_pixel(1'b0);
        e1  = ref_pixel(1'b1);
        vin = 1'b1;
        tick();
        vin = 1'b0;
        for (int c = 1; c < 4; c++) begin
            chk({tag, "_lat"}, bus0.valid_out, 0);
            tick();
        end
        chk({tag, "_vld0"}, bus0.valid_out, 1);
        chk({tag, "_vld1"}, bus1.valid_out, 1);
        chk({tag, "_dat0"}, bus0.o_data, e0);
        chk({tag, "_dat1"}, bus1.o_data, e1);
    endtask

    task automatic set_weights(input longint w, input longint b);
        for (int k = 0; k < 9; k++) mw[k] = w;
        mb = b;
    endtask

    task automatic rand_weights(input longint lim);
        for (int k = 0; k < 9; k++) mw[k] = rnd(-lim, lim - 1);
        mb = rnd(-lim, lim - 1);
    endtask

    initial begin
        rst = 1'b1;
        vin = 1'b0;
        wv  = 1'b0;
        wc  = 1'b0;
        wd  = '0;
        set_taps(0);
        #12;
        chk("rst_valid_out", bus0.valid_out, 0);
        chk("rst_o_data", bus0.o_data, 0);
        chk("rst_w_ready", bus0.w_ready, 0);
        tick();
        rst = 1'b0;

        // Windows before any weights are loaded must vanish
        set_taps(256);
        vin = 1'b1;
        repeat (3) tick();
        vin = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("gate_unloaded", bus0.valid_out, 0);
        end

        // Unity weights; a window alongside the 10th word is dropped
        set_weights(256, 0);
        load_words(1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("drop_on_last_word", bus0.valid_out, 0);
        end
        set_taps(256);
        run_window("ones");
        chk("ones_const", bus0.o_data, 2304);
        tick();
        chk("hold_valid", bus0.valid_out, 0);
        chk("hold_data", bus0.o_data, 2304);

        // Rounding and bias
        set_weights(0, 256);
        mw[4] = 128;
        load_words(1'b0, 1'b0);
        rand_taps();
        taps[4] = 16'sd1;
        run_window("round_pos");
        chk("round_pos_const", bus0.o_data, 257);
        taps[4] = -16'sd1;
        run_window("round_neg");
        chk("round_neg_const", bus0.o_data, 256);

        // Saturation both ways, ReLU clamp
        set_weights(32767, 0);
        load_words(1'b0, 1'b0);
        set_taps(32767);
        run_window("sat_pos");
        chk("sat_pos_const", bus0.o_data, 32767);
        set_weights(-32768, 0);
        load_words(1'b0, 1'b0);
        run_window("sat_neg");
        chk("sat_neg_const", bus0.o_data, -32768);
        chk("sat_neg_relu", bus1.o_data, 0);
        set_weights(-256, 0);
        load_words(1'b0, 1'b0);
        set_taps(256);
        run_window("relu");
        chk("relu_const", bus1.o_data, 0);
        chk("relu_off_const", bus0.o_data, -2304);

        // Clear after five words, then a fresh full load
        wc = 1'b1;
        tick();
        wc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wv = 1'b1;
            wd = BIT'(rnd(-32768, 32767));
            tick();
        end
        wv = 1'b0;
        chk("partial_ready", bus0.w_ready, 0);
        rand_weights(32768);
        load_words(1'b0, 1'b0);
        rand_taps();
        run_window("after_clear");

        // Clear coincident with a word: the word must not shift the sequence
        rand_weights(2048);
        load_words(1'b0, 1'b1);
        for (int n = 0; n < 4; n++) begin
            rand_taps();
            run_window("rand_coincide");
        end

        // 20 back-to-back ramp windows
        rand_weights(512);
        load_words(1'b0, 1'b0);
        for (int c = 0; c < 23; c++) begin
            if (c < 20) begin
                for (int k = 0; k < 9; k++) taps[k] = BIT'(c * 40 + k * 13 - 200);
                vin    = 1'b1;
                e0q[c] = ref_pixel(1'b0);
                e1q[c] = ref_pixel(1'b1);
            end else begin
                vin = 1'b0;
            end
            tick();
            if (c >= 3) begin
                chk("stream_vld", bus0.valid_out, 1);
                chk("stream_dat0", bus0.o_data, e0q[c-3]);
                chk("stream_dat1", bus1.o_data, e1q[c-3]);
            end else begin
                chk("stream_fill", bus0.valid_out, 0);
            end
        end
        tick();
        chk("stream_end", bus0.valid_out, 0);

        // Reset on cycle 2 of a stream discards everything in flight
        for (int c = 0; c < 3; c++) begin
            rand_taps();
            vin = 1'b1;
            if (c < 2) tick();
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus0.valid_out, 0);
        chk("mid_rst_data", bus0.o_data, 0);
        chk("mid_rst_ready", bus0.w_ready, 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("post_rst_quiet0", bus0.valid_out, 0);
            chk("post_rst_quiet1", bus1.valid_out, 0);
        end
        vin = 1'b0;

        // Recovery after a full reload
        rand_weights(32768);
        load_words(1'b0, 1'b0);
        rand_taps();
        run_window("recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
